// File: rtl/io_config_dispatch.sv
// Single-entry IO command dispatcher: latches one core command, drives the addressed
// config cell's handshake, and returns load responses (or zero on timeout/invalid cell).
module io_config_dispatch #(
    parameter int DATABITWIDTH   = 16,
    parameter int CELLCOUNT      = 4,
    parameter int CELLWINDOWBITS = 1,
    parameter int TIMEOUTCYCLES  = 255
) (
    input  logic                              sys_clk,
    input  logic                              sync_rst,
    input  logic                              clk_en,
    input  logic                              CmdACK,
    output logic                              CmdREQ,
    input  logic                              CmdLoadEn,
    input  logic [3:0]                        CmdMinorOpcode,
    input  logic [DATABITWIDTH-1:0]           CmdAddr,
    input  logic [15:0]                       CmdData,
    input  logic [3:0]                        CmdRegDest,
    output logic [CELLCOUNT-1:0]              CellConfigACK,
    input  logic [CELLCOUNT-1:0]              CellConfigREQ,
    output logic                              LoadEn,
    output logic [3:0]                        MinorOpcodeOut,
    output logic [DATABITWIDTH-1:0]           DataAddrOffsetOut,
    output logic [15:0]                       ConfigWordOut,
    output logic [3:0]                        ConfigRegDestOut,
    input  logic [CELLCOUNT-1:0]              CellResponseACK,
    output logic [CELLCOUNT-1:0]              CellResponseREQ,
    input  logic [4*CELLCOUNT-1:0]            CellResponseRegDest,
    input  logic [DATABITWIDTH*CELLCOUNT-1:0] CellResponseData,
    output logic                              WritebackACK,
    input  logic                              WritebackREQ,
    output logic [3:0]                        WritebackRegDest,
    output logic [DATABITWIDTH-1:0]           WritebackData,
    output logic                              TimeoutErr
);

    localparam int IDXBITS = (CELLCOUNT > 1) ? $clog2(CELLCOUNT) : 1;
    localparam logic [DATABITWIDTH-1:0] OFFSET_MASK =
        DATABITWIDTH'((64'(1) << CELLWINDOWBITS) - 64'(1));
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUTCYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WB
    } state_t;

    state_t                  state_q, state_d;
    logic                    load_en_q, load_en_d;
    logic [3:0]              minor_q, minor_d;
    logic [DATABITWIDTH-1:0] offset_q, offset_d;
    logic [15:0]             data_q, data_d;
    logic [3:0]              reg_dest_q, reg_dest_d;
    logic [IDXBITS-1:0]      idx_q, idx_d;
    logic [DATABITWIDTH-1:0] resp_data_q, resp_data_d;
    logic [3:0]              resp_dest_q, resp_dest_d;
    logic [7:0]              count_q, count_d;
    logic                    timeout_err_q, timeout_err_d;

    logic [IDXBITS-1:0]      cmd_idx;
    logic                    cmd_idx_valid;
    logic [CELLCOUNT-1:0]    sel_oh;
    logic                    complete;
    logic                    resp_fire;
    logic                    timeout_hit;

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < CELLCOUNT; i++) begin
            if (idx_q == IDXBITS'(i)) begin
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign cmd_idx       = CmdAddr[CELLWINDOWBITS +: IDXBITS];
    assign cmd_idx_valid = 32'(cmd_idx) < CELLCOUNT;
    assign complete      = |(sel_oh & CellConfigREQ);
    assign resp_fire     = load_en_q && |(sel_oh & CellResponseACK);
    assign timeout_hit   = (TIMEOUTCYCLES != 0) && (count_q == TIMEOUT_LAST);

    always_comb begin
        state_d       = state_q;
        load_en_d     = load_en_q;
        minor_d       = minor_q;
        offset_d      = offset_q;
        data_d        = data_q;
        reg_dest_d    = reg_dest_q;
        idx_d         = idx_q;
        resp_data_d   = resp_data_q;
        resp_dest_d   = resp_dest_q;
        count_d       = count_q;
        timeout_err_d = timeout_err_q;

        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (CmdACK) begin
                        load_en_d  = CmdLoadEn;
                        minor_d    = CmdMinorOpcode;
                        offset_d   = CmdAddr & OFFSET_MASK;
                        data_d     = CmdData;
                        reg_dest_d = CmdRegDest;
                        idx_d      = cmd_idx;
                        count_d    = '0;
                        if (cmd_idx_valid) begin
                            state_d = ISSUE;
                        end else if (CmdLoadEn) begin
                            state_d     = WB;
                            resp_data_d = '0;
                            resp_dest_d = CmdRegDest;
                        end
                    end
                end
                ISSUE: begin
                    if (resp_fire) begin
                        for (int i = 0; i < CELLCOUNT; i++) begin
                            if (sel_oh[i]) begin
                                resp_data_d = CellResponseData[DATABITWIDTH*i +: DATABITWIDTH];
                                resp_dest_d = CellResponseRegDest[4*i +: 4];
                            end
                        end
                    end
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (complete) begin
                        state_d = load_en_q ? WB : IDLE;
                    end else if (timeout_hit) begin
                        timeout_err_d = 1'b1;
                        if (load_en_q) begin
                            state_d     = WB;
                            resp_data_d = '0;
                            resp_dest_d = reg_dest_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
                WB: begin
                    if (WritebackREQ) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            state_q       <= IDLE;
            load_en_q     <= 1'b0;
            minor_q       <= '0;
            offset_q      <= '0;
            data_q        <= '0;
            reg_dest_q    <= '0;
            idx_q         <= '0;
            resp_data_q   <= '0;
            resp_dest_q   <= '0;
            count_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_en_q     <= load_en_d;
            minor_q       <= minor_d;
            offset_q      <= offset_d;
            data_q        <= data_d;
            reg_dest_q    <= reg_dest_d;
            idx_q         <= idx_d;
            resp_data_q   <= resp_data_d;
            resp_dest_q   <= resp_dest_d;
            count_q       <= count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign CmdREQ            = clk_en && (state_q == IDLE);
    assign CellConfigACK     = (clk_en && state_q == ISSUE) ? sel_oh : '0;
    assign CellResponseREQ   = (clk_en && state_q == ISSUE && load_en_q) ? sel_oh : '0;
    assign WritebackACK      = clk_en && (state_q == WB);
    assign LoadEn            = load_en_q;
    assign MinorOpcodeOut    = minor_q;
    assign DataAddrOffsetOut = offset_q;
    assign ConfigWordOut     = data_q;
    assign ConfigRegDestOut  = reg_dest_q;
    assign WritebackData     = resp_data_q;
    assign WritebackRegDest  = resp_dest_q;
    assign TimeoutErr        = timeout_err_q;

endmodule

// File: tb/tb_io_config_dispatch.sv
// Scoreboard bench for io_config_dispatch: three cells (index 3 aliases to an absent
// cell) and a 4-cycle timeout, with a simple cell model that echoes the dest register.
module tb_io_config_dispatch;

    localparam int DW = 16;
    localparam int CC = 3;

    logic              sys_clk = 1'b0;
    logic              sync_rst;
    logic              clk_en;
    logic              CmdACK;
    logic              CmdREQ;
    logic              CmdLoadEn;
    logic [3:0]        CmdMinorOpcode;
    logic [DW-1:0]     CmdAddr;
    logic [15:0]       CmdData;
    logic [3:0]        CmdRegDest;
    logic [CC-1:0]     CellConfigACK;
    logic [CC-1:0]     CellConfigREQ;
    logic              LoadEn;
    logic [3:0]        MinorOpcodeOut;
    logic [DW-1:0]     DataAddrOffsetOut;
    logic [15:0]       ConfigWordOut;
    logic [3:0]        ConfigRegDestOut;
    logic [CC-1:0]     CellResponseACK;
    logic [CC-1:0]     CellResponseREQ;
    logic [4*CC-1:0]   CellResponseRegDest;
    logic [DW*CC-1:0]  CellResponseData;
    logic              WritebackACK;
    logic              WritebackREQ;
    logic [3:0]        WritebackRegDest;
    logic [DW-1:0]     WritebackData;
    logic              TimeoutErr;

    logic [CC-1:0]     cell_ready;
    logic [DW-1:0]     cell_data [CC];
    logic [19:0]       exp_q [$];
    int                checks = 0;
    int                errors = 0;

    always #5 sys_clk = ~sys_clk;

    io_config_dispatch #(
        .DATABITWIDTH(DW),
        .CELLCOUNT(CC),
        .CELLWINDOWBITS(1),
        .TIMEOUTCYCLES(4)
    ) dut (
        .sys_clk(sys_clk),
        .sync_rst(sync_rst),
        .clk_en(clk_en),
        .CmdACK(CmdACK),
        .CmdREQ(CmdREQ),
        .CmdLoadEn(CmdLoadEn),
        .CmdMinorOpcode(CmdMinorOpcode),
        .CmdAddr(CmdAddr),
        .CmdData(CmdData),
        .CmdRegDest(CmdRegDest),
        .CellConfigACK(CellConfigACK),
        .CellConfigREQ(CellConfigREQ),
        .LoadEn(LoadEn),
        .MinorOpcodeOut(MinorOpcodeOut),
        .DataAddrOffsetOut(DataAddrOffsetOut),
        .ConfigWordOut(ConfigWordOut),
        .ConfigRegDestOut(ConfigRegDestOut),
        .CellResponseACK(CellResponseACK),
        .CellResponseREQ(CellResponseREQ),
        .CellResponseRegDest(CellResponseRegDest),
        .CellResponseData(CellResponseData),
        .WritebackACK(WritebackACK),
        .WritebackREQ(WritebackREQ),
        .WritebackRegDest(WritebackRegDest),
        .WritebackData(WritebackData),
        .TimeoutErr(TimeoutErr)
    );

    // A ready cell also answers immediately, echoing the destination register.
    assign CellConfigREQ   = cell_ready;
    assign CellResponseACK = cell_ready;
    always_comb begin
        CellResponseData    = '0;
        CellResponseRegDest = '0;
        for (int i = 0; i < CC; i++) begin
            CellResponseData[DW*i +: DW] = cell_data[i];
            CellResponseRegDest[4*i +: 4] = ConfigRegDestOut;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ld, input logic [DW-1:0] addr,
                                 input logic [15:0] data, input logic [3:0] dest);
        CmdLoadEn      = ld;
        CmdMinorOpcode = 4'h3;
        CmdAddr        = addr;
        CmdData        = data;
        CmdRegDest     = dest;
        CmdACK         = 1'b1;
        #1;
        checkOutput("cmd_req_accept", 32'(CmdREQ), 32'd1);
        cycle();
        CmdACK = 1'b0;
    endtask

    task automatic popWriteback(input string tag);
        logic [19:0] exp_v;
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp_v = exp_q.pop_front();
            checkOutput({tag, "_wb_data"}, 32'(WritebackData), 32'(exp_v[15:0]));
            checkOutput({tag, "_wb_dest"}, 32'(WritebackRegDest), 32'(exp_v[19:16]));
        end
    endtask

    task automatic doReset();
        sync_rst = 1'b1;
        cycle();
        cycle();
    endtask

    initial begin
        clk_en         = 1'b1;
        CmdACK         = 1'b0;
        CmdLoadEn      = 1'b0;
        CmdMinorOpcode = '0;
        CmdAddr        = '0;
        CmdData        = '0;
        CmdRegDest     = '0;
        WritebackREQ   = 1'b0;
        cell_ready     = '0;
        cell_data[0]   = 16'h1234;
        cell_data[1]   = 16'h00AB;
        cell_data[2]   = 16'h0C0D;

        doReset();
        checkOutput("rst_cmd_req", 32'(CmdREQ), 32'd1);
        checkOutput("rst_cfg_ack", 32'(CellConfigACK), 32'd0);
        checkOutput("rst_resp_req", 32'(CellResponseREQ), 32'd0);
        checkOutput("rst_wb_ack", 32'(WritebackACK), 32'd0);
        checkOutput("rst_wb_data", 32'(WritebackData), 32'd0);
        checkOutput("rst_wb_dest", 32'(WritebackRegDest), 32'd0);
        checkOutput("rst_timeout", 32'(TimeoutErr), 32'd0);
        checkOutput("rst_word", 32'(ConfigWordOut), 32'd0);
        sync_rst = 1'b0;
        cell_ready = 3'b111;

        $display("[TB] store to cell 2");
        applyStimulus(1'b0, 16'h0004, 16'h8005, 4'h0);
        checkOutput("st_cfg_ack", 32'(CellConfigACK), 32'b100);
        checkOutput("st_word", 32'(ConfigWordOut), 32'h8005);
        checkOutput("st_offset", 32'(DataAddrOffsetOut), 32'd0);
        checkOutput("st_resp_req", 32'(CellResponseREQ), 32'd0);
        checkOutput("st_cmd_req_busy", 32'(CmdREQ), 32'd0);
        cycle();
        checkOutput("st_cmd_req_n2", 32'(CmdREQ), 32'd1);
        checkOutput("st_cfg_ack_n2", 32'(CellConfigACK), 32'd0);

        $display("[TB] load from cell 1");
        exp_q.push_back({4'd7, 16'h00AB});
        applyStimulus(1'b1, 16'h0003, 16'h0000, 4'd7);
        checkOutput("ld_cfg_ack", 32'(CellConfigACK), 32'b010);
        checkOutput("ld_resp_req", 32'(CellResponseREQ), 32'b010);
        checkOutput("ld_offset", 32'(DataAddrOffsetOut), 32'd1);
        checkOutput("ld_load_en", 32'(LoadEn), 32'd1);
        cycle();
        for (int k = 0; k < 3; k++) begin
            checkOutput("ld_wb_ack_hold", 32'(WritebackACK), 32'd1);
            checkOutput("ld_wb_data_hold", 32'(WritebackData), 32'h00AB);
            checkOutput("ld_cmd_req_hold", 32'(CmdREQ), 32'd0);
            cycle();
        end
        popWriteback("ld");
        WritebackREQ = 1'b1;
        cycle();
        WritebackREQ = 1'b0;
        checkOutput("ld_wb_ack_done", 32'(WritebackACK), 32'd0);
        checkOutput("ld_cmd_req_done", 32'(CmdREQ), 32'd1);

        $display("[TB] invalid cell index");
        exp_q.push_back({4'd5, 16'h0000});
        applyStimulus(1'b1, 16'h0006, 16'h0000, 4'd5);
        checkOutput("inv_ld_cfg_ack", 32'(CellConfigACK), 32'd0);
        checkOutput("inv_ld_wb_ack", 32'(WritebackACK), 32'd1);
        popWriteback("inv_ld");
        WritebackREQ = 1'b1;
        cycle();
        WritebackREQ = 1'b0;
        checkOutput("inv_ld_cmd_req", 32'(CmdREQ), 32'd1);
        applyStimulus(1'b0, 16'h0006, 16'h5555, 4'd0);
        checkOutput("inv_st_cmd_req", 32'(CmdREQ), 32'd1);
        checkOutput("inv_st_cfg_ack", 32'(CellConfigACK), 32'd0);
        checkOutput("inv_st_wb_ack", 32'(WritebackACK), 32'd0);

        $display("[TB] timeout on a stalled cell");
        cell_ready = 3'b000;
        exp_q.push_back({4'd9, 16'h0000});
        applyStimulus(1'b1, 16'h0000, 16'h0000, 4'd9);
        for (int k = 0; k < 4; k++) begin
            checkOutput("to_cfg_ack", 32'(CellConfigACK), 32'b001);
            checkOutput("to_err_early", 32'(TimeoutErr), 32'd0);
            cycle();
        end
        checkOutput("to_wb_ack", 32'(WritebackACK), 32'd1);
        checkOutput("to_err_set", 32'(TimeoutErr), 32'd1);
        popWriteback("to");
        WritebackREQ = 1'b1;
        cycle();
        WritebackREQ = 1'b0;
        checkOutput("to_err_sticky", 32'(TimeoutErr), 32'd1);
        doReset();
        sync_rst = 1'b0;
        checkOutput("to_err_cleared", 32'(TimeoutErr), 32'd0);

        $display("[TB] clock enable drop mid-issue");
        exp_q.push_back({4'd3, 16'h0C0D});
        applyStimulus(1'b1, 16'h0004, 16'h0000, 4'd3);
        checkOutput("ce_cfg_ack_c0", 32'(CellConfigACK), 32'b100);
        cycle();
        clk_en = 1'b0;
        #1;
        checkOutput("ce_cfg_ack_off", 32'(CellConfigACK), 32'd0);
        checkOutput("ce_resp_req_off", 32'(CellResponseREQ), 32'd0);
        cycle();
        cycle();
        clk_en = 1'b1;
        #1;
        checkOutput("ce_cfg_ack_c1", 32'(CellConfigACK), 32'b100);
        cycle();
        checkOutput("ce_cfg_ack_c2", 32'(CellConfigACK), 32'b100);
        cycle();
        // Cell becomes ready on the very cycle the timeout would otherwise fire.
        cell_ready = 3'b100;
        #1;
        checkOutput("ce_cfg_ack_c3", 32'(CellConfigACK), 32'b100);
        cycle();
        cell_ready = 3'b000;
        checkOutput("ce_wb_ack", 32'(WritebackACK), 32'd1);
        checkOutput("ce_no_timeout", 32'(TimeoutErr), 32'd0);
        popWriteback("ce");

        $display("[TB] reset during writeback");
        sync_rst = 1'b1;
        cycle();
        sync_rst = 1'b0;
        checkOutput("rwb_wb_ack", 32'(WritebackACK), 32'd0);
        checkOutput("rwb_wb_data", 32'(WritebackData), 32'd0);
        checkOutput("rwb_cmd_req", 32'(CmdREQ), 32'd1);
        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
